// File: rtl/ram_arbiter_pkg.sv
// Shared types for the i/d RAM arbiter: bus word, RAM status and arbiter FSM state.
package ram_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    localparam int STARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF    = 64;

    // A write counts as a data request even when dREN is low.
    function automatic logic d_request(input logic ren, input logic wen);
        return ren | wen;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundles the pipeline request/response signals and the RAM port seen by the arbiter.
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    logic      halt;
    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      iwait;
    logic      dwait;
    word_t     iload;
    word_t     dload;
    logic      ierr;
    logic      derr;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    // slave: the arbiter itself; master: whoever drives requests and models the RAM
    modport slave (
        input  halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ierr, derr, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ierr, derr, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: data side has priority, instruction side is protected by a
// starvation limit, and every grant is bounded by a timeout.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF     // must be >= 2
) (
    input  logic         CLK,
    input  logic         nRST,
    ram_arbiter_if.slave bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    arb_state_t    state_q,   state_d;
    logic [SW-1:0] starve_q,  starve_d;
    logic [TW-1:0] timeout_q, timeout_d;

    logic d_req;
    assign d_req = d_request(bus.dREN, bus.dWEN);

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        timeout_d    = timeout_q;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ierr     = 1'b0;
        bus.derr     = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        case (state_q)
            IDLE: begin
                timeout_d = '0;
                if (d_req && (starve_q < STARVE_LIM || !bus.iREN || bus.halt)) begin
                    state_d = DGRANT;
                    // Only reachable below the limit, so the increment saturates by construction.
                    if (bus.iREN && !bus.halt)
                        starve_d = starve_q + 1'b1;
                end else if (bus.iREN && !bus.halt) begin
                    state_d = IGRANT;
                end
            end

            IGRANT: begin
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr;
                    timeout_d   = timeout_q + 1'b1;
                    if (bus.ramstate == ACCESS) begin
                        bus.iwait = 1'b0;
                        bus.iload = bus.ramload;
                        starve_d  = '0;
                        state_d   = IDLE;
                    end else if (bus.ramstate == ERROR || timeout_q == TO_LAST) begin
                        bus.iwait = 1'b0;
                        bus.ierr  = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end

            DGRANT: begin
                if (!d_req) begin
                    state_d = IDLE;
                end else begin
                    bus.ramREN   = bus.dREN & ~bus.dWEN;
                    bus.ramWEN   = bus.dWEN;
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    timeout_d    = timeout_q + 1'b1;
                    if (bus.ramstate == ACCESS) begin
                        bus.dwait = 1'b0;
                        bus.dload = bus.ramload;
                        state_d   = IDLE;
                    end else if (bus.ramstate == ERROR || timeout_q == TO_LAST) begin
                        bus.dwait = 1'b0;
                        bus.derr  = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            timeout_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
